// File: rtl/fdtd_pkg.sv
// Shared FDTD types and default latencies.
// Used by the Ez sweep controller and its tag delay line.
package fdtd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } ez_sweep_state_t;

    localparam int FDTD_RD_LAT      = 1;
    localparam int FDTD_EZ_CORE_LAT = 6;

endpackage

// File: rtl/fdtd_tag_delay.sv
// Fixed-depth shift register of {valid, addr} tags.
// Aligns each issued read with its core result.
module fdtd_tag_delay
    import fdtd_pkg::*;
#(
    parameter int DEPTH      = FDTD_RD_LAT + FDTD_EZ_CORE_LAT,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr
);

    logic [DEPTH-1:0]      vld;
    logic [ADDR_WIDTH-1:0] adr [DEPTH];

    // Shift tags one stage per cycle; reset drops every tag in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld <= '0;
            for (int k = 0; k < DEPTH; k++) adr[k] <= '0;
        end else begin
            vld[0] <= in_valid;
            adr[0] <= in_addr;
            for (int k = 1; k < DEPTH; k++) begin
                vld[k] <= vld[k-1];
                adr[k] <= adr[k-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_addr  = adr[DEPTH-1];

endmodule

// File: rtl/fdtd_ez_sweep_ctrl.sv
// Ez sweep sequencer: streams cell reads, gates the core,
// and writes core results back to the Ez RAM.
module fdtd_ez_sweep_ctrl
    import fdtd_pkg::*;
#(
    parameter int FDTD_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int RD_LATENCY      = FDTD_RD_LAT,
    parameter int CORE_LATENCY    = FDTD_EZ_CORE_LAT
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       start,
    input  logic [ADDR_WIDTH:0]        cell_num,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic                       core_clken,
    input  logic [FDTD_DATA_WIDTH-1:0] core_ez_i,
    output logic                       ez_wr_en,
    output logic [ADDR_WIDTH-1:0]      ez_wr_addr,
    output logic [FDTD_DATA_WIDTH-1:0] ez_wr_data
);

    localparam int L   = RD_LATENCY + CORE_LATENCY;
    localparam int DCW = $clog2(L + 1);

    ez_sweep_state_t     state;
    logic [ADDR_WIDTH:0] n_lat;
    logic [ADDR_WIDTH:0] idx;
    logic [DCW-1:0]      dcnt;
    logic                tag_in_valid;
    logic [ADDR_WIDTH-1:0] tag_in_addr;

    // Sequence IDLE -> ISSUE -> DRAIN -> FIN with registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            n_lat      <= '0;
            idx        <= '0;
            dcnt       <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            busy       <= 1'b0;
            core_clken <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cell_num >= (ADDR_WIDTH+1)'(2)) begin
                            n_lat      <= cell_num;
                            idx        <= '0;
                            rd_addr    <= '0;
                            rd_en      <= 1'b1;
                            busy       <= 1'b1;
                            core_clken <= 1'b1;
                            state      <= S_ISSUE;
                        end else begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end
                S_ISSUE: begin
                    if (idx == n_lat - 1'b1) begin
                        rd_en <= 1'b0;
                        dcnt  <= '0;
                        state <= S_DRAIN;
                    end else begin
                        idx     <= idx + 1'b1;
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (dcnt == DCW'(L - 1)) begin
                        busy       <= 1'b0;
                        core_clken <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_FIN;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                S_FIN: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Cell 0 is the PEC boundary, so its tag is never marked valid.
    assign tag_in_valid = rd_en && (rd_addr != '0);
    assign tag_in_addr  = rd_en ? rd_addr : '0;

    fdtd_tag_delay #(
        .DEPTH      (L),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_tag (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (tag_in_valid),
        .in_addr   (tag_in_addr),
        .out_valid (ez_wr_en),
        .out_addr  (ez_wr_addr)
    );

    assign ez_wr_data = core_ez_i;

endmodule
